// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store over valid/ready,
// commits it after a fixed latency, and pulses a one-cycle response while stalling the pipeline.
module dmem_responder #(
    parameter int DEPTH_WORDS = 32,
    parameter int LATENCY     = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        stall_o,
    output logic [1:0]  state_dbg_o
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
    localparam bit          DIRECT    = (LATENCY == 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q;
    logic [31:0]       addr_q, wdata_q;
    logic              accept, commit;
    logic              c_write, c_err;
    logic [31:0]       c_addr, c_wdata;
    logic [IDX_W-1:0]  c_idx;
    logic [31:0]       mem [DEPTH_WORDS];

    // Handshake: a request transfers on a rising edge where req_valid_i and
    // req_ready_o are both high; ready is high only in IDLE and never in reset.
    assign req_ready_o = rst_n_i & (state_q == ST_IDLE);
    assign accept      = req_valid_i & req_ready_o;
    assign stall_o     = rst_n_i & (((state_q == ST_IDLE) & req_valid_i) | (state_q == ST_WAIT));
    assign state_dbg_o = state_q;

    // With single-cycle latency the commit happens on the accept edge, so the
    // live request inputs are used instead of the not-yet-latched copy.
    assign c_write = (state_q == ST_IDLE) ? req_write_i : wr_q;
    assign c_addr  = (state_q == ST_IDLE) ? req_addr_i  : addr_q;
    assign c_wdata = (state_q == ST_IDLE) ? req_wdata_i : wdata_q;
    assign c_err   = (c_addr[1:0] != 2'b00) | (c_addr[31:2] >= DEPTH_LIM);
    assign c_idx   = c_addr[IDX_W+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d = CNT_INIT;
                    if (DIRECT) begin
                        commit  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Commit on the edge where the countdown reaches zero.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    commit  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            wr_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= 32'd0;
            resp_err_o   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_o <= commit;
            if (accept) begin
                wr_q    <= req_write_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
            end
            if (commit) begin
                resp_err_o   <= c_err;
                resp_rdata_o <= (c_write | c_err) ? 32'd0 : mem[c_idx];
            end
        end
    end

    // Array is not reset; a reset coinciding with the commit edge blocks the write.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && commit && c_write && !c_err) begin
            mem[c_idx] <= c_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=4 instance and a LATENCY=1 instance
// share one request bus; expected values are hand-computed constants.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        a_ready, a_resp_valid, a_err, a_stall;
    logic [31:0] a_rdata;
    logic [1:0]  a_state;
    logic        b_ready, b_resp_valid, b_err, b_stall;
    logic [31:0] b_rdata;
    logic [1:0]  b_state;

    int total = 0;
    int bad   = 0;

    dmem_responder #(.DEPTH_WORDS(32), .LATENCY(4)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(a_ready),
        .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(a_resp_valid), .resp_rdata_o(a_rdata), .resp_err_o(a_err),
        .stall_o(a_stall), .state_dbg_o(a_state)
    );

    dmem_responder #(.DEPTH_WORDS(32), .LATENCY(1)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(b_ready),
        .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(b_resp_valid), .resp_rdata_o(b_rdata), .resp_err_o(b_err),
        .stall_o(b_stall), .state_dbg_o(b_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input bit s);
        return s ? b_ready : a_ready;
    endfunction

    function automatic logic rsp(input bit s);
        return s ? b_resp_valid : a_resp_valid;
    endfunction

    function automatic logic stl(input bit s);
        return s ? b_stall : a_stall;
    endfunction

    // Issue one request on the selected instance and collect its response.
    // lat counts cycles from acceptance to the response cycle.
    task automatic do_req(input bit sel, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output int stall_cnt,
                          output logic stall_at_resp, output logic [31:0] rdata,
                          output logic err);
        int guard;
        guard     = 0;
        stall_cnt = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        #1;
        while (!rdy(sel) && guard < 20) begin
            step();
            guard++;
        end
        if (stl(sel)) stall_cnt++;
        step();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp(sel) && lat < 30) begin
            if (stl(sel)) stall_cnt++;
            step();
            lat++;
        end
        stall_at_resp = stl(sel);
        rdata = sel ? b_rdata : a_rdata;
        err   = sel ? b_err : a_err;
        step();
    endtask

    initial begin
        int          lat, scnt, acc2, resp1, resp2, rd_hi, pulses;
        logic        sres, err;
        logic [31:0] rdata, r1, r2;

        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        step();
        step();
        chk("rst_ready", {31'd0, a_ready}, 32'd0);
        chk("rst_stall", {31'd0, a_stall}, 32'd0);
        chk("rst_resp_valid", {31'd0, a_resp_valid}, 32'd0);
        chk("rst_rdata", a_rdata, 32'd0);
        chk("rst_err", {31'd0, a_err}, 32'd0);
        chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
        rst_n     = 1'b1;
        req_valid = 1'b0;
        step();
        chk("idle_ready", {31'd0, a_ready}, 32'd1);
        chk("idle_state", {30'd0, a_state}, 32'd0);

        do_req(0, 1'b1, 32'h08, 32'h08080808, lat, scnt, sres, rdata, err);
        do_req(0, 1'b1, 32'h0C, 32'h0C0C0C0C, lat, scnt, sres, rdata, err);
        do_req(0, 1'b1, 32'h00, 32'h11111111, lat, scnt, sres, rdata, err);
        do_req(0, 1'b1, 32'h04, 32'h22222222, lat, scnt, sres, rdata, err);

        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, lat, scnt, sres, rdata, err);
        chk("st_latency", lat, 32'd4);
        chk("st_err", {31'd0, err}, 32'd0);
        chk("st_rdata", rdata, 32'd0);

        do_req(0, 1'b0, 32'h10, 32'd0, lat, scnt, sres, rdata, err);
        chk("ld_rdata", rdata, 32'hDEADBEEF);
        chk("ld_latency", lat, 32'd4);
        chk("ld_stall_cycles", scnt, 32'd4);
        chk("ld_stall_in_resp", {31'd0, sres}, 32'd0);

        do_req(0, 1'b1, 32'h11, 32'h12345678, lat, scnt, sres, rdata, err);
        chk("mis_err", {31'd0, err}, 32'd1);
        do_req(0, 1'b0, 32'h10, 32'd0, lat, scnt, sres, rdata, err);
        chk("mis_keep_rdata", rdata, 32'hDEADBEEF);
        chk("mis_keep_err", {31'd0, err}, 32'd0);

        do_req(0, 1'b0, 32'h80, 32'd0, lat, scnt, sres, rdata, err);
        chk("oor_err", {31'd0, err}, 32'd1);
        chk("oor_rdata", rdata, 32'd0);

        // Back-to-back loads with valid held high; inputs disturbed during WAIT.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        #1;
        chk("b2b_ready_first", {31'd0, a_ready}, 32'd1);
        step();
        acc2 = -1; resp1 = -1; resp2 = -1; rd_hi = 0;
        r1 = 32'd0; r2 = 32'd0;
        for (int k = 0; k < 12; k++) begin
            if (k == 0) begin
                req_write = 1'b1;
                req_addr  = 32'h4;
                req_wdata = 32'hBAD0BAD0;
            end
            if (k == 2) begin
                req_write = 1'b0;
                req_addr  = 32'h4;
            end
            #1;
            if (k <= 3 && a_ready) rd_hi++;
            if (a_resp_valid) begin
                if (resp1 < 0) begin
                    resp1 = k;
                    r1 = a_rdata;
                end else begin
                    resp2 = k;
                    r2 = a_rdata;
                end
            end
            if (a_ready && acc2 < 0) acc2 = k + 1;
            step();
            if (acc2 == k + 1) req_valid = 1'b0;
        end
        chk("b2b_ready_low", rd_hi, 32'd0);
        chk("b2b_resp1_cycle", resp1, 32'd3);
        chk("b2b_resp1_data", r1, 32'h11111111);
        chk("b2b_accept_gap", acc2, 32'd5);
        chk("b2b_resp2_cycle", resp2, 32'd8);
        chk("b2b_resp2_data", r2, 32'h22222222);

        // Reset two cycles after accepting a store.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h8;
        req_wdata = 32'hAAAA5555;
        #1;
        chk("rw_ready", {31'd0, a_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        chk("rw_resp_valid", {31'd0, a_resp_valid}, 32'd0);
        chk("rw_rdata", a_rdata, 32'd0);
        chk("rw_err", {31'd0, a_err}, 32'd0);
        chk("rw_stall", {31'd0, a_stall}, 32'd0);
        chk("rw_ready_rst", {31'd0, a_ready}, 32'd0);
        rst_n = 1'b1;
        pulses = 0;
        repeat (8) begin
            if (a_resp_valid) pulses++;
            step();
        end
        chk("rw_no_pulse", pulses, 32'd0);
        do_req(0, 1'b0, 32'h8, 32'd0, lat, scnt, sres, rdata, err);
        chk("rw_old_value", rdata, 32'h08080808);

        // Reset on the commit edge itself.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'hC;
        req_wdata = 32'h5A5A5A5A;
        #1;
        step();
        req_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("rc_resp_valid", {31'd0, a_resp_valid}, 32'd0);
        rst_n = 1'b1;
        pulses = 0;
        repeat (6) begin
            if (a_resp_valid) pulses++;
            step();
        end
        chk("rc_no_pulse", pulses, 32'd0);
        do_req(0, 1'b0, 32'hC, 32'd0, lat, scnt, sres, rdata, err);
        chk("rc_old_value", rdata, 32'h0C0C0C0C);

        // Single-cycle latency instance.
        do_req(1, 1'b1, 32'h4, 32'h13572468, lat, scnt, sres, rdata, err);
        chk("l1_st_latency", lat, 32'd1);
        chk("l1_st_err", {31'd0, err}, 32'd0);
        chk("l1_st_rdata", rdata, 32'd0);
        do_req(1, 1'b0, 32'h4, 32'd0, lat, scnt, sres, rdata, err);
        chk("l1_ld_latency", lat, 32'd1);
        chk("l1_ld_rdata", rdata, 32'h13572468);
        chk("l1_ld_stall_cycles", scnt, 32'd1);
        chk("l1_ld_stall_in_resp", {31'd0, sres}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
